// File: rtl/dsp_write_sequencer.sv
// Trigger-synchronous sequencer: replays a preloaded queue of (addr, data) bus writes on a
// trigger edge. Define DSP_SEQ_REPLAY_EN to keep the queue and re-run it on every trigger.
module dsp_write_sequencer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   ld_valid_i,
  output logic                   ld_ready_o,
  input  logic [AW-1:0]          ld_addr_i,
  input  logic [DW-1:0]          ld_data_i,
  input  logic                   arm_i,
  input  logic                   abort_i,
  input  logic                   trig_i,
  output logic [AW-1:0]          m_addr_o,
  output logic [DW-1:0]          m_wdata_o,
  output logic [3:0]             m_sel_o,
  output logic                   m_wen_o,
  output logic                   m_ren_o,
  input  logic                   m_ack_i,
  input  logic                   m_err_i,
  output logic                   busy_o,
  output logic                   armed_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {StIdle, StArmed, StIssue, StWait} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, ex_ptr_q, ex_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d, rem_q, rem_d;
  logic [7:0]    tmo_q, tmo_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          err_q, err_d, done_q, done_d;
  logic          trig_q, trig_q2, edge_q;
  logic          done_now, flush, ld_accept;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  assign ld_ready_o = (state_q == StIdle) && (cnt_q < CW'(DEPTH));
  assign ld_accept  = ld_valid_i && ld_ready_o;

  always_ff @(posedge clk_i) begin
    if (ld_accept) begin
      addr_mem[wr_ptr_q] <= ld_addr_i;
      data_mem[wr_ptr_q] <= ld_data_i;
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    ex_ptr_d = ex_ptr_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    tmo_d    = tmo_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    done_d   = 1'b0;
    done_now = 1'b0;
    flush    = 1'b0;

    if (ld_accept) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      cnt_d    = cnt_q + CW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (arm_i) begin
          state_d = StArmed;
          err_d   = 1'b0;
        end
      end
      StArmed: begin
        if (edge_q) begin
          if (cnt_q != '0) begin
            state_d  = StIssue;
            ex_ptr_d = rd_ptr_q;
            rem_d    = cnt_q;
            tmo_d    = '0;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      StIssue: begin
        addr_d  = addr_mem[ex_ptr_q];
        wdata_d = data_mem[ex_ptr_q];
        tmo_d   = tmo_q + 8'd1;
        state_d = StWait;
      end
      StWait: begin
        tmo_d = tmo_q + 8'd1;
        if (m_ack_i && m_err_i) begin
          err_d   = 1'b1;
          flush   = 1'b1;
          state_d = StIdle;
        end else if (m_ack_i) begin
          // An ack wins over a timeout reached in the same cycle.
          ex_ptr_d = ex_ptr_q + PW'(1);
          rem_d    = rem_q - CW'(1);
`ifndef DSP_SEQ_REPLAY_EN
          rd_ptr_d = rd_ptr_q + PW'(1);
          cnt_d    = cnt_q - CW'(1);
`endif
          if (rem_q == CW'(1)) begin
            done_now = 1'b1;
`ifdef DSP_SEQ_REPLAY_EN
            state_d  = StArmed;
`else
            state_d  = StIdle;
`endif
          end else begin
            state_d = StIssue;
            tmo_d   = '0;
          end
        end else if (tmo_q == 8'(TIMEOUT)) begin
          err_d   = 1'b1;
          flush   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort_i) begin
      state_d  = StIdle;
      err_d    = err_q;
      done_d   = 1'b0;
      done_now = 1'b0;
      flush    = 1'b1;
    end

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= StIdle;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      ex_ptr_q <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      tmo_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      trig_q   <= 1'b0;
      trig_q2  <= 1'b0;
      edge_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      ex_ptr_q <= ex_ptr_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      tmo_q    <= tmo_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      done_q   <= done_d;
      trig_q   <= trig_i;
      trig_q2  <= trig_q;
      edge_q   <= trig_q & ~trig_q2;
    end
  end

  // During ISSUE the bus sees the head entry directly; afterwards the captured copy holds.
  assign m_addr_o  = (state_q == StIssue) ? addr_mem[ex_ptr_q] : addr_q;
  assign m_wdata_o = (state_q == StIssue) ? data_mem[ex_ptr_q] : wdata_q;
  assign m_sel_o   = 4'hF;
  assign m_ren_o   = 1'b0;
  assign m_wen_o   = (state_q == StIssue);
  assign busy_o    = (state_q != StIdle);
  assign armed_o   = (state_q == StArmed);
  assign done_o    = done_q | done_now;
  assign err_o     = err_q;
  assign count_o   = cnt_q;

endmodule

// File: tb/tb_dsp_write_sequencer.sv
// Scoreboard bench for dsp_write_sequencer: a queue model predicts the write stream and done
// pulses; a negedge monitor checks every bus write and done pulse as it appears.
module tb_dsp_write_sequencer;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic ld_valid = 0, arm = 0, abort = 0, trig = 0;
  logic [31:0] ld_addr = 0, ld_data = 0;
  logic ld_ready, m_wen_o, m_ren_o, busy_o, armed_o, done_o, err_o;
  logic [31:0] m_addr_o, m_wdata_o;
  logic [3:0]  m_sel_o;
  logic [4:0]  count_o;
  logic s_ack = 0, s_err = 0, man_ack = 0, m_ack;

  assign m_ack = s_ack | man_ack;

  dsp_write_sequencer #(.DEPTH(DEPTH), .AW(32), .DW(32), .TIMEOUT(15)) dut (
    .clk_i(clk), .rstn_i(rst_n), .ld_valid_i(ld_valid), .ld_ready_o(ld_ready),
    .ld_addr_i(ld_addr), .ld_data_i(ld_data), .arm_i(arm), .abort_i(abort), .trig_i(trig),
    .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o), .m_sel_o(m_sel_o), .m_wen_o(m_wen_o),
    .m_ren_o(m_ren_o), .m_ack_i(m_ack), .m_err_i(s_err), .busy_o(busy_o), .armed_o(armed_o),
    .done_o(done_o), .err_o(err_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  ent_t model_q[$];
  ent_t exp_q[$];
  int   exp_done = 0;
  int   wen_log[$];
  int   done_log[$];
  int   slave_dly = 0;
  bit   err_inj = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: every write and done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_wen_o) begin
        wen_log.push_back(cyc);
        if (exp_q.size() == 0) check("unexpected_wen", 1, 0);
        else begin
          ent_t e;
          e = exp_q.pop_front();
          check("wr_addr", m_addr_o, e.a);
          check("wr_data", m_wdata_o, e.d);
        end
      end
      if (done_o) begin
        done_log.push_back(cyc);
        if (exp_done == 0) check("unexpected_done", 1, 0);
        else exp_done--;
      end
    end
  end

  // Bus slave: acks slave_dly cycles after the cycle following wen; negative delay never acks.
  always begin
    bit pend;
    int dly;
    @(negedge clk);
    if (!rst_n) pend = 0;
    else if (m_wen_o && slave_dly >= 0) begin pend = 1; dly = slave_dly; end
    @(posedge clk); #1;
    s_ack = 0; s_err = 0;
    if (!rst_n) pend = 0;
    else if (pend) begin
      if (dly == 0) begin s_ack = 1; s_err = err_inj; pend = 0; end
      else dly--;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    bit rdy;
    ld_valid = 1; ld_addr = a; ld_data = d;
    #1;
    rdy = (model_q.size() < DEPTH);
    check("ld_ready", ld_ready, rdy);
    if (rdy) model_q.push_back('{a: a, d: d});
    tick();
  endtask

  task automatic trig_pulse(input bit exp_d, output int t0);
    trig = 1; t0 = cyc;
    foreach (model_q[i]) exp_q.push_back(model_q[i]);
`ifndef DSP_SEQ_REPLAY_EN
    model_q.delete();
`endif
    if (exp_d) exp_done++;
    tick();
    trig = 0;
  endtask

  task automatic arm_trig(input bit exp_d, output int t0);
    arm = 1; tick(); arm = 0;
    check("armed_after_arm", armed_o, 1);
    check("err_cleared_by_arm", err_o, 0);
    trig_pulse(exp_d, t0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 300) begin tick(); n++; end
    check("reached_idle", busy_o, 0);
    repeat (3) tick();
  endtask

  task automatic wait_err();
    int n = 0;
    while (!err_o && n < 80) begin tick(); n++; end
    check("err_raised", err_o, 1);
  endtask

  task automatic wait_wens(input int k);
    int n = 0;
    while (wen_log.size() < k && n < 80) begin tick(); n++; end
    check("wen_seen", wen_log.size() >= k, 1);
  endtask

  task automatic clear_logs();
    wen_log.delete(); done_log.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, e0, nent;
    #12;
    check("rst_ld_ready", ld_ready, 1);
    check("rst_sel", m_sel_o, 4'hF);
    check("rst_outs", {m_wen_o, m_ren_o, busy_o, armed_o, done_o, err_o}, 6'b0);
    check("rst_count", count_o, 0);
    check("rst_addr", m_addr_o, 0);
    check("rst_wdata", m_wdata_o, 0);
    @(posedge clk); #1; rst_n = 1;
    tick();

`ifdef DSP_SEQ_REPLAY_EN
    slave_dly = 0; clear_logs();
    load(32'h4030_0000, 32'hA); load(32'h4031_0004, 32'h3); ld_valid = 0;
    arm_trig(1, t0);
    wait_wens(2); repeat (4) tick();
    for (int k = 2; k <= 3; k++) begin
      trig_pulse(1, t0);
      wait_wens(2 * k); repeat (4) tick();
    end
    check("replay_wens", wen_log.size(), 6);
    check("replay_dones", done_log.size(), 3);
    check("replay_count", count_o, 2);
    check("replay_armed", armed_o, 1);
    check("replay_sb_empty", exp_q.size(), 0);
`else
    // Directed three-entry run with a zero-wait slave.
    slave_dly = 0; clear_logs();
    load(32'h4030_0000, 32'h0000_000A);
    load(32'h4031_0004, 32'h0000_0003);
    load(32'h4030_000C, 32'h0000_00FF);
    ld_valid = 0;
    check("count_after_load", count_o, 3);
    arm_trig(1, t0);
    wait_idle();
    check("dir_wen_count", wen_log.size(), 3);
    for (int i = 0; i < wen_log.size() && i < 3; i++)
      check("dir_wen_time", wen_log[i] - t0, 3 + 2 * i);
    check("dir_done_count", done_log.size(), 1);
    if (done_log.size() > 0) check("dir_done_time", done_log[0] - t0, 8);
    check("dir_count_end", count_o, 0);

    // Timeout: slave never answers.
    slave_dly = -1; clear_logs();
    load(32'h4032_0000, 32'h1234_5678); ld_valid = 0;
    arm_trig(0, t0);
    wait_err();
    e0 = cyc;
    check("to_wen_count", wen_log.size(), 1);
    if (wen_log.size() > 0) check("to_err_time", e0 - wen_log[0], 16);
    check("to_flushed", count_o, 0);
    wait_idle();
    check("to_no_done", done_log.size(), 0);

    // Overfill: DEPTH+2 loads with ld_valid held high.
    slave_dly = $urandom_range(0, 4); clear_logs();
    for (int i = 0; i < DEPTH + 2; i++) load($urandom, $urandom);
    ld_valid = 0;
    check("full_count", count_o, DEPTH);
    check("full_ready", ld_ready, 0);
    arm_trig(1, t0);
    wait_idle();
    check("full_wens", wen_log.size(), DEPTH);
    check("full_sb_empty", exp_q.size(), 0);

    // Empty queue trigger.
    clear_logs();
    arm_trig(1, t0);
    wait_idle();
    check("empty_no_wen", wen_log.size(), 0);
    check("empty_done_count", done_log.size(), 1);
    if (done_log.size() > 0) check("empty_done_time", done_log[0] - t0, 3);
    check("empty_armed", armed_o, 0);

    // Bus error on the first of two writes.
    slave_dly = 0; err_inj = 1; clear_logs();
    load(32'h4033_0000, 32'h1); load(32'h4033_0004, 32'h2); ld_valid = 0;
    arm_trig(0, t0);
    wait_err();
    wait_idle();
    err_inj = 0;
    check("buserr_wens", wen_log.size(), 1);
    check("buserr_count", count_o, 0);
    check("buserr_no_done", done_log.size(), 0);
    exp_q.delete();

    // Randomised rounds.
    for (int r = 0; r < 6; r++) begin
      slave_dly = $urandom_range(0, 6);
      nent = $urandom_range(1, 6);
      for (int i = 0; i < nent; i++) load($urandom, $urandom);
      ld_valid = 0;
      check("rnd_count", count_o, nent);
      arm_trig(1, t0);
      wait_idle();
      check("rnd_sb_empty", exp_q.size(), 0);
      check("rnd_done_left", exp_done, 0);
    end

    // Abort during entry 2 of 4, with an ack in the same cycle.
    slave_dly = -1; clear_logs();
    for (int i = 0; i < 4; i++) load(32'h4040_0000 + 4 * i, $urandom);
    ld_valid = 0;
    arm_trig(0, t0);
    wait_wens(1);
    man_ack = 1; tick(); man_ack = 0;
    wait_wens(2);
    man_ack = 1; abort = 1; tick(); man_ack = 0; abort = 0;
    exp_q.delete();
    check("abort_idle", busy_o, 0);
    check("abort_count", count_o, 0);
    repeat (6) tick();
    check("abort_wens", wen_log.size(), 2);
    check("abort_no_done", done_log.size(), 0);
    check("abort_err", err_o, 0);

    // Asynchronous reset mid-sequence.
    slave_dly = 2; clear_logs();
    for (int i = 0; i < 3; i++) load($urandom, $urandom);
    ld_valid = 0;
    arm_trig(1, t0);
    wait_wens(1);
    #2 rst_n = 0;
    #1;
    check("arst_outs", {m_wen_o, m_ren_o, busy_o, armed_o, done_o, err_o}, 6'b0);
    check("arst_count", count_o, 0);
    check("arst_ready", ld_ready, 1);
    check("arst_addr", m_addr_o, 0);
    check("arst_wdata", m_wdata_o, 0);
    exp_q.delete(); exp_done = 0;
    @(posedge clk); #1; rst_n = 1;
    repeat (3) tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
